// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and a variable-latency instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch plus IF/ID register: variable-latency imem, one-entry
// stall hold buffer, decode redirects. Optional counters under FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stallD,
  input  logic                 jumpD,
  input  logic                 pcsrcD,
  input  logic [31:0]          pcjumpD,
  input  logic [31:0]          pcbranchD,
  fetch_stage_if.master        imem,
  output logic [31:0]          instrD,
  output logic [31:0]          pcplus4D,
  output logic                 validD,
  output logic [5:0]           opD,
  output logic [5:0]           functD,
`ifdef FETCH_PERF_EN
  output logic [31:0]          perf_insts,
  output logic [31:0]          perf_bubbles,
`endif
  output logic                 imem_waitF
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        ifid_load;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc4F;

  assign redirect = valid_q & ~stallD & (jumpD | pcsrcD);
  assign target   = jumpD ? pcjumpD : pcbranchD;
  assign pc4F     = pc_q + 32'd4;

  assign imem.imem_req  = (state_q != S_HOLD);
  assign imem.imem_addr = pc_q;
  assign imem_waitF     = ((state_q == S_FETCH) & ~imem.imem_ready) | (state_q == S_DRAIN);

  assign instrD   = instr_q;
  assign pcplus4D = pcplus4_q;
  assign validD   = valid_q;
  assign opD      = instr_q[31:26];
  assign functD   = instr_q[5:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pcplus4_d     = pcplus4_q;
    valid_d       = valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    redirect_pc_d = redirect_pc_q;
    ifid_load     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          ifid_load = 1'b1;
          instr_d   = 32'd0;
          valid_d   = 1'b0;
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            redirect_pc_d = target;
            state_d       = S_DRAIN;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc4F;
          if (!stallD) begin
            ifid_load = 1'b1;
            instr_d   = imem.imem_rdata;
            pcplus4_d = pc4F;
            valid_d   = 1'b1;
          end else begin
            // Response arrived while decode is frozen: park it until the stall ends.
            hold_instr_d = imem.imem_rdata;
            hold_pc4_d   = pc4F;
            state_d      = S_HOLD;
          end
        end else if (!stallD) begin
          ifid_load = 1'b1;
          instr_d   = 32'd0;
          valid_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          ifid_load = 1'b1;
          instr_d   = 32'd0;
          valid_d   = 1'b0;
          pc_d      = target;
          state_d   = S_FETCH;
        end else if (!stallD) begin
          ifid_load = 1'b1;
          instr_d   = hold_instr_q;
          pcplus4_d = hold_pc4_q;
          valid_d   = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Old address stays on the bus until the wrong-path response is swallowed.
        if (!stallD) begin
          ifid_load = 1'b1;
          instr_d   = 32'd0;
          valid_d   = 1'b0;
        end
        if (imem.imem_ready) begin
          pc_d    = redirect_pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      pcplus4_q     <= 32'd0;
      valid_q       <= 1'b0;
      hold_instr_q  <= 32'd0;
      hold_pc4_q    <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pcplus4_q     <= pcplus4_d;
      valid_q       <= valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc4_q    <= hold_pc4_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_insts_q, perf_bubbles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_insts_q   <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else if (ifid_load) begin
      if (valid_d) perf_insts_q   <= perf_insts_q + 32'd1;
      else         perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_insts   = perf_insts_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_load;
  assign unused_load = ifid_load;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Owns pcF and drives the instruction-memory request interface, which has variable latency.
- Produces instrD and pcplus4D, and derives opD/functD directly from instrD for the decode-stage controller.
- Absorbs decode stalls with a one-entry hold buffer and applies jump/branch redirects from decode, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pcF on reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- stallD  in  1  hazard unit holds decode; IF/ID must not change.
- jumpD  in  1  jump in decode.
- pcsrcD  in  1  taken branch in decode.
- pcjumpD  in  32  jump target.
- pcbranchD  in  32  branch target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response valid this cycle; completes the request.
- imem_rdata  in  32  instruction word, valid with imem_ready.
- instrD  out  32  IF/ID instruction; 0 (NOP) when bubble.
- pcplus4D  out  32  IF/ID PC+4.
- validD  out  1  IF/ID holds a real instruction.
- opD  out  6  instrD[31:26], combinational.
- functD  out  6  instrD[5:0], combinational.
- imem_waitF  out  1  fetch is waiting on memory (FETCH with !imem_ready, or DRAIN).

Behaviour:
- Reset values: pcF=RESET_PC; instrD=0; pcplus4D=0; validD=0; state=FETCH; hold and redirect registers=0. Reset is effective mid-request: the outstanding response is abandoned and imem_req is re-issued from RESET_PC.
- redirect = validD & !stallD & (jumpD | pcsrcD).
- Redirect target: pcjumpD if jumpD, else pcbranchD. Jump has priority when both are asserted.
- Redirects are ignored when validD=0 or stallD=1.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Targets are used unaligned as given.
- FSM state FETCH: imem_req=1, imem_addr=pcF.
  - redirect & imem_ready: drop rdata; IF/ID<=bubble; pcF<=target; stay in FETCH.
  - redirect & !imem_ready: IF/ID<=bubble; redirect_pc<=target; go to DRAIN.
  - imem_ready & !stallD: instrD<=rdata; pcplus4D<=pcF+4; validD<=1; pcF<=pcF+4.
  - imem_ready & stallD: hold<={rdata, pcF+4}; pcF<=pcF+4; IF/ID unchanged; go to HOLD.
  - !imem_ready & !stallD: IF/ID<=bubble.
  - !imem_ready & stallD: IF/ID unchanged.
- FSM state HOLD: imem_req=0.
  - stallD: stay in HOLD.
  - redirect: discard hold; IF/ID<=bubble; pcF<=target; go to FETCH.
  - otherwise: IF/ID<=hold with validD=1; go to FETCH. Next fetch issues the following cycle.
- FSM state DRAIN: imem_req=1, imem_addr=pcF (old address, kept stable).
  - imem_ready: discard rdata; pcF<=redirect_pc; go to FETCH.
  - IF/ID<=bubble whenever stallD=0.
- Latency: zero-wait memory (ready in the request cycle) delivers one instruction per cycle. Each instruction appears in instrD the edge after imem_ready.
- Redirect penalty: one bubble if ready coincides with the redirect, otherwise one bubble per DRAIN cycle plus one.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_insts[31:0] and perf_bubbles[31:0].
  - perf_insts counts edges on which IF/ID loads a valid instruction.
  - perf_bubbles counts edges on which IF/ID loads a bubble.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset released, memory always ready, rdata=addr -> imem_addr 0,4,8; instrD 0,4,8 on consecutive edges; pcplus4D 4,8,12; validD=1 from the first post-reset edge.
- Ready delayed 3 cycles for addr 0 -> imem_waitF=1 for 3 cycles, imem_addr held at 0, validD=0 bubbles, then instrD=rdata and pcplus4D=4.
- stallD=1 for 2 cycles while ready at addr 8 -> state HOLD, imem_req=0, IF/ID unchanged; after the stall instrD=word@8, then fetch resumes at 12.
- jumpD=1, pcjumpD=0x100, validD=1, ready same cycle -> next instrD=0 with validD=0; imem_addr=0x100 the next cycle.
- pcsrcD=1, pcbranchD=0x40 while a request to 0x10 is pending 2 cycles -> DRAIN keeps imem_addr=0x10; the response is discarded; the next request is to 0x40; no wrong-path instruction has validD=1.
- reset pulled low during DRAIN -> all outputs at reset values immediately; after release imem_addr=RESET_PC.
